// File: rtl/regfile_sb_pkg.sv
// Shared constants for the regfile_sb register file and its scoreboard counters.
package regfile_sb_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_DATA_W-1:0] ZeroWord = '0;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

endpackage

// File: rtl/regfile_sb_cnt.sv
// One saturating in-flight counter for a single register; flush wins over inc/dec.
module regfile_sb_cnt
    import regfile_sb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_max_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            // A write-back with nothing in flight (e.g. after a flush) is legal and ignored.
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with per-register write-pending scoreboard.
// Optional same-cycle write-back bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              iss_we_i,
    input  logic [ADDR_W-1:0] iss_addr_i,
    input  logic              flush_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              sb_ovf_o
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];

    logic [NREG-1:1]   inc_vec;
    logic [NREG-1:1]   dec_vec;
    logic [NREG-1:1]   at_max_vec;
    logic [CNT_W-1:0]  cnt_w [NREG];

    logic              sb_ovf_q;
    logic              sb_ovf_d;
    logic              ovf_set;

    logic              re_v    [2];
    logic [ADDR_W-1:0] raddr_v [2];
    logic [DATA_W-1:0] rdata_v [2];
    logic              busy_v  [2];

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
        end
        if ((wb_we_i == WriteEnable) && (wb_addr_i != '0)) begin
            mem_d[wb_addr_i] = wb_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = (iss_we_i == WriteEnable) && (iss_addr_i == ADDR_W'(r));
            dec_vec[r] = (wb_we_i == WriteEnable) && (wb_addr_i == ADDR_W'(r));
        end
    end

    assign cnt_w[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        regfile_sb_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc_i    (inc_vec[r]),
            .dec_i    (dec_vec[r]),
            .flush_i  (flush_i),
            .cnt_o    (cnt_w[r]),
            .at_max_o (at_max_vec[r])
        );
    end

    // Sticky: any issue that lands on a full counter without a cancelling write-back.
    always_comb begin
        ovf_set  = |(inc_vec & at_max_vec & ~dec_vec);
        sb_ovf_d = sb_ovf_q | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            sb_ovf_q <= 1'b0;
        end else begin
            sb_ovf_q <= sb_ovf_d;
        end
    end

    assign sb_ovf_o = sb_ovf_q;

    assign re_v[0]    = re1_i;
    assign re_v[1]    = re2_i;
    assign raddr_v[0] = raddr1_i;
    assign raddr_v[1] = raddr2_i;

    always_comb begin
`ifdef REGFILE_BYPASS_EN
        logic wb_hit;
        wb_hit = 1'b0;
`endif
        for (int p = 0; p < 2; p++) begin
            rdata_v[p] = DATA_W'(ZeroWord);
            busy_v[p]  = 1'b0;
            if ((rst != RstEnable) && (re_v[p] == ReadEnable) && (raddr_v[p] != '0)) begin
`ifdef REGFILE_BYPASS_EN
                wb_hit     = (wb_we_i == WriteEnable) && (wb_addr_i == raddr_v[p]);
                rdata_v[p] = wb_hit ? wb_data_i : mem_q[raddr_v[p]];
                // The last outstanding producer is retiring right now, so no stall needed.
                busy_v[p]  = (cnt_w[raddr_v[p]] != '0) &&
                             !(wb_hit && (cnt_w[raddr_v[p]] == CNT_W'(1)));
`else
                rdata_v[p] = mem_q[raddr_v[p]];
                busy_v[p]  = (cnt_w[raddr_v[p]] != '0);
`endif
            end
        end
    end

    assign rdata1_o = rdata_v[0];
    assign rdata2_o = rdata_v[1];
    assign busy1_o  = busy_v[0];
    assign busy2_o  = busy_v[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default CNT_W=2, 32x32 storage).
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        iss_we_i;
    logic [4:0]  iss_addr_i;
    logic        flush_i;
    logic        re1_i, re2_i;
    logic [4:0]  raddr1_i, raddr2_i;
    logic [31:0] rdata1_o, rdata2_o;
    logic        busy1_o, busy2_o;
    logic        sb_ovf_o;

    int checks   = 0;
    int failures = 0;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we_i    (wb_we_i),
        .wb_addr_i  (wb_addr_i),
        .wb_data_i  (wb_data_i),
        .iss_we_i   (iss_we_i),
        .iss_addr_i (iss_addr_i),
        .flush_i    (flush_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata1_o   (rdata1_o),
        .rdata2_o   (rdata2_o),
        .busy1_o    (busy1_o),
        .busy2_o    (busy2_o),
        .sb_ovf_o   (sb_ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we_i  = 1'b0;
        iss_we_i = 1'b0;
        flush_i  = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_we_i   = 1'b1;
        wb_addr_i = a;
        wb_data_i = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_we_i   = 1'b1;
        iss_addr_i = a;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        re1_i    = 1'b1;
        raddr1_i = a1;
        re2_i    = 1'b1;
        raddr2_i = a2;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wb_addr_i = '0; wb_data_i = '0; iss_addr_i = '0;
        re1_i = 1'b0; re2_i = 1'b0; raddr1_i = '0; raddr2_i = '0;
        idle();
        tick();
        tick();

        // Reads during reset are forced to zero.
        rd(5'd5, 5'd6);
        chk("rst_rdata1", rdata1_o, 32'h0);
        chk("rst_busy1", {31'b0, busy1_o}, 32'h0);
        chk("rst_ovf", {31'b0, sb_ovf_o}, 32'h0);
        rst = 1'b0;

        // Write r5, read on both ports next cycle.
        wb(5'd5, 32'h1234_5678);
        tick();
        idle();
        rd(5'd5, 5'd5);
        chk("wr_rd1", rdata1_o, 32'h1234_5678);
        chk("wr_rd2", rdata2_o, 32'h1234_5678);
        chk("wr_busy1", {31'b0, busy1_o}, 32'h0);
        chk("wr_busy2", {31'b0, busy2_o}, 32'h0);
        re1_i = 1'b0;
        #1;
        chk("re0_rdata1", rdata1_o, 32'h0);

        // r0 is never written.
        wb(5'd0, 32'hFFFF_FFFF);
        tick();
        idle();
        rd(5'd0, 5'd0);
        chk("r0_rd", rdata1_o, 32'h0);

        // Same-cycle write/read of r7.
        wb(5'd7, 32'h1111_1111);
        tick();
        wb(5'd7, 32'hA5A5_A5A5);
        rd(5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
        chk("bypass_rd", rdata1_o, 32'hA5A5_A5A5);
`else
        chk("bypass_rd", rdata1_o, 32'h1111_1111);
`endif
        tick();
        idle();
        rd(5'd7, 5'd7);
        chk("after_bypass_rd", rdata1_o, 32'hA5A5_A5A5);

        // Two issues to r3, then drain.
        iss(5'd3);
        tick();
        iss(5'd3);
        tick();
        idle();
        rd(5'd3, 5'd3);
        chk("sb_busy_cnt2", {31'b0, busy1_o}, 32'h1);
        wb(5'd3, 32'h33);
        #1;
        chk("sb_busy_cnt2_wb", {31'b0, busy1_o}, 32'h1);
        tick();
        idle();
        #1;
        chk("sb_busy_cnt1", {31'b0, busy1_o}, 32'h1);
        wb(5'd3, 32'h34);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("sb_busy_cnt1_wb", {31'b0, busy1_o}, 32'h0);
`else
        chk("sb_busy_cnt1_wb", {31'b0, busy1_o}, 32'h1);
`endif
        tick();
        idle();
        #1;
        chk("sb_busy_cnt0", {31'b0, busy2_o}, 32'h0);
        chk("sb_rd_r3", rdata2_o, 32'h34);

        // Simultaneous issue and write-back leaves the count unchanged.
        iss(5'd3);
        tick();
        iss(5'd3);
        wb(5'd3, 32'h35);
        tick();
        idle();
        #1;
        chk("sb_incdec_busy", {31'b0, busy1_o}, 32'h1);
        wb(5'd3, 32'h36);
        tick();
        idle();
        #1;
        chk("sb_incdec_drain", {31'b0, busy1_o}, 32'h0);

        // Saturation of r9 at 3.
        for (int i = 0; i < 3; i++) begin
            iss(5'd9);
            tick();
        end
        idle();
        #1;
        chk("sat_ovf_pre", {31'b0, sb_ovf_o}, 32'h0);
        iss(5'd9);
        tick();
        idle();
        rd(5'd9, 5'd9);
        chk("sat_ovf", {31'b0, sb_ovf_o}, 32'h1);
        chk("sat_busy", {31'b0, busy1_o}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            wb(5'd9, 32'h90 + 32'(i));
            tick();
        end
        idle();
        #1;
        chk("sat_busy_cnt1", {31'b0, busy1_o}, 32'h1);
        wb(5'd9, 32'h99);
        tick();
        idle();
        #1;
        chk("sat_busy_cnt0", {31'b0, busy1_o}, 32'h0);
        chk("sat_ovf_sticky", {31'b0, sb_ovf_o}, 32'h1);

        // Flush with a concurrent write-back.
        iss(5'd4);
        tick();
        iss(5'd6);
        tick();
        idle();
        rd(5'd4, 5'd6);
        chk("fl_busy4_pre", {31'b0, busy1_o}, 32'h1);
        chk("fl_busy6_pre", {31'b0, busy2_o}, 32'h1);
        flush_i = 1'b1;
        wb(5'd4, 32'h55);
        tick();
        idle();
        #1;
        chk("fl_busy4", {31'b0, busy1_o}, 32'h0);
        chk("fl_busy6", {31'b0, busy2_o}, 32'h0);
        chk("fl_rd4", rdata1_o, 32'h55);
        wb(5'd4, 32'h66);
        tick();
        idle();
        #1;
        chk("stray_busy", {31'b0, busy1_o}, 32'h0);
        iss(5'd4);
        tick();
        idle();
        #1;
        chk("stray_iss_busy", {31'b0, busy1_o}, 32'h1);
        wb(5'd4, 32'h67);
        tick();
        idle();
        #1;
        chk("stray_drain", {31'b0, busy1_o}, 32'h0);

        // Reset mid-operation discards simultaneous issue and write.
        wb(5'd1, 32'hDEAD_BEEF);
        tick();
        iss(5'd1);
        wb_we_i = 1'b0;
        tick();
        idle();
        rd(5'd1, 5'd2);
        chk("pre_rst_rd1", rdata1_o, 32'hDEAD_BEEF);
        chk("pre_rst_busy1", {31'b0, busy1_o}, 32'h1);
        rst = 1'b1;
        iss(5'd2);
        wb(5'd2, 32'h77);
        #1;
        chk("in_rst_rd1", rdata1_o, 32'h0);
        chk("in_rst_busy1", {31'b0, busy1_o}, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("post_rst_rd1", rdata1_o, 32'h0);
        chk("post_rst_busy1", {31'b0, busy1_o}, 32'h0);
        chk("post_rst_rd2", rdata2_o, 32'h0);
        chk("post_rst_busy2", {31'b0, busy2_o}, 32'h0);
        chk("post_rst_ovf", {31'b0, sb_ovf_o}, 32'h0);
        rd(5'd5, 5'd7);
        chk("post_rst_r5", rdata1_o, 32'h0);
        chk("post_rst_r7", rdata2_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
